load_store_unit: RTL and testbench

- MEM-stage initiator for the byte-addressed, big-endian data memory of the 32-bit MIPS pipeline.
- Accepts one load/store per request from the pipeline and handles sub-word sizes (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Drives a word-aligned request/acknowledge memory port with byte enables.
- Stalls the pipeline until the access completes; returns aligned, sign- or zero-extended load data.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// big-endian byte-lane enable patterns (byte offset 0 is enable bit 3).
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store-side enables/replication/misalign from the
// incoming access, load-side extract and sign/zero extension from latched fields.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_offset,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_byte_en  = BE_WORD;
        o_wdata    = i_store_data;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_byte_en = BE_BYTE0 >> i_offset;
                o_wdata   = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
                o_byte_en  = i_offset[1] ? BE_HALF_LO : BE_HALF_HI;
                o_wdata    = {2{i_store_data[15:0]}};
                o_misalign = i_offset[0];
            end
            // the illegal size encoding behaves exactly like a word
            default: o_misalign = |i_offset;
        endcase
    end

    always_comb begin
        w_ld_byte   = i_rdata[31:24];
        w_ld_half   = i_ld_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
        o_load_data = i_rdata;
        case (i_ld_offset)
            2'd0:    w_ld_byte = i_rdata[31:24];
            2'd1:    w_ld_byte = i_rdata[23:16];
            2'd2:    w_ld_byte = i_rdata[15:8];
            default: w_ld_byte = i_rdata[7:0];
        endcase
        case (i_ld_size)
            SZ_BYTE: o_load_data = {{24{~i_ld_unsigned & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_load_data = {{16{~i_ld_unsigned & w_ld_half[15]}}, w_ld_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a big-endian word-addressed memory port.
// Define LSU_TIMEOUT_EN to add an ack timeout that ends the access with bus_err_out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_valid_in,
    input  logic              ls_write_in,
    input  logic [1:0]        ls_size_in,
    input  logic              ls_unsigned_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic [DATA_W-1:0] load_data_out,
    output logic              done_out,
    output logic              stall_out,
    output logic              misalign_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic [3:0]        mem_byte_en_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    input  logic              mem_ack_in,
`ifdef LSU_TIMEOUT_EN
    output logic              bus_err_out,
`endif
    output logic [1:0]        dbg_state_out
);

    // Handshakes: the pipeline holds its access while stall_out is high and the
    // access is finished in the single done_out cycle; the memory sees a request
    // whose fields are stable from mem_req_out rising until the cycle it acks.

    lsu_state_e        r_state;
    lsu_state_e        w_next_state;
    logic              w_accept;
    logic              w_ack_take;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_mem_we;
    logic [1:0]        r_ld_size;
    logic [1:0]        r_ld_offset;
    logic              r_ld_unsigned;
    logic [DATA_W-1:0] r_load_data;
    logic              r_misalign;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_wdata;
    logic              w_misalign;
    logic [31:0]       w_load_data;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            r_bus_err;
`endif

    lsu_lane_align u_lane_align (
        .i_size        (ls_size_in),
        .i_offset      (addr_in[1:0]),
        .i_store_data  (store_data_in),
        .o_byte_en     (w_byte_en),
        .o_wdata       (w_wdata),
        .o_misalign    (w_misalign),
        .i_ld_size     (r_ld_size),
        .i_ld_offset   (r_ld_offset),
        .i_ld_unsigned (r_ld_unsigned),
        .i_rdata       (mem_rdata_in),
        .o_load_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ack_take   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        stall_out    = 1'b0;
        mem_req_out  = 1'b0;
        done_out     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall_out = ls_valid_in;
                if (ls_valid_in) begin
                    w_accept     = 1'b1;
                    w_next_state = w_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall_out   = 1'b1;
                mem_req_out = 1'b1;
                if (mem_ack_in) begin
                    w_ack_take   = 1'b1;
                    w_next_state = ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                done_out     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_mem_we      <= 1'b0;
            r_ld_size     <= SZ_WORD;
            r_ld_offset   <= 2'd0;
            r_ld_unsigned <= 1'b0;
            r_load_data   <= '0;
            r_misalign    <= 1'b0;
        end else begin
            // a faulting access never touches the memory-side registers
            if (w_accept && w_misalign) begin
                r_misalign <= 1'b1;
            end else if (w_accept) begin
                r_mem_addr    <= {addr_in[ADDR_W-1:2], 2'b00};
                r_mem_wdata   <= w_wdata;
                r_mem_be      <= w_byte_en;
                r_mem_we      <= ls_write_in;
                r_ld_size     <= ls_size_in;
                r_ld_offset   <= addr_in[1:0];
                r_ld_unsigned <= ls_unsigned_in;
            end
            if (w_ack_take && !r_mem_we) r_load_data <= w_load_data;
            if (r_state == ST_DONE) r_misalign <= 1'b0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_accept) r_to_cnt <= '0;
            else if (r_state == ST_REQ && !mem_ack_in) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_timeout) r_bus_err <= 1'b1;
            else if (r_state == ST_DONE) r_bus_err <= 1'b0;
        end
    end

    assign bus_err_out = r_bus_err;
`endif

    assign load_data_out   = r_load_data;
    assign misalign_out    = r_misalign;
    assign mem_we_out      = r_mem_we;
    assign mem_addr_out    = r_mem_addr;
    assign mem_wdata_out   = r_mem_wdata;
    assign mem_byte_en_out = r_mem_be;
    assign dbg_state_out   = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: timeline-driven accesses with a behavioural
// lane/extension model, per-cycle output comparison and literal anchor checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_valid_in;
    logic        ls_write_in;
    logic [1:0]  ls_size_in;
    logic        ls_unsigned_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [31:0] load_data_out;
    logic        done_out;
    logic        stall_out;
    logic        misalign_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_byte_en_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;
    logic [1:0]  dbg_state_out;
`ifdef LSU_TIMEOUT_EN
    logic        bus_err_out;
`endif

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ls_valid_in     (ls_valid_in),
        .ls_write_in     (ls_write_in),
        .ls_size_in      (ls_size_in),
        .ls_unsigned_in  (ls_unsigned_in),
        .addr_in         (addr_in),
        .store_data_in   (store_data_in),
        .load_data_out   (load_data_out),
        .done_out        (done_out),
        .stall_out       (stall_out),
        .misalign_out    (misalign_out),
        .mem_req_out     (mem_req_out),
        .mem_we_out      (mem_we_out),
        .mem_addr_out    (mem_addr_out),
        .mem_wdata_out   (mem_wdata_out),
        .mem_byte_en_out (mem_byte_en_out),
        .mem_rdata_in    (mem_rdata_in),
        .mem_ack_in      (mem_ack_in),
`ifdef LSU_TIMEOUT_EN
        .bus_err_out     (bus_err_out),
`endif
        .dbg_state_out   (dbg_state_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expectations for the current cycle, set by the driver
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_done, exp_mis, exp_we, exp_bus_err;
    logic [31:0] exp_load, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          tcyc;

    // observations of the current transaction, used by the literal checks
    int          first_req_t, done_t, req_cycles;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] first_lane;
        first_lane = 4'b1000;
        if (sz == 2'b00) return first_lane >> off;
        if (sz == 2'b01) return (off == 2'd0) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(off));
            v  = (rd >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
            return v;
        end
        if (sz == 2'b01) begin
            sh = (off == 2'd0) ? 16 : 0;
            v  = (rd >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
            return v;
        end
        return rd;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall_out}, {31'd0, exp_stall});
            chk("mem_req", {31'd0, mem_req_out}, {31'd0, exp_req});
            chk("done", {31'd0, done_out}, {31'd0, exp_done});
            chk("misalign", {31'd0, misalign_out}, {31'd0, exp_mis});
            chk("load_data", load_data_out, exp_load);
`ifdef LSU_TIMEOUT_EN
            chk("bus_err", {31'd0, bus_err_out}, {31'd0, exp_bus_err});
`endif
            if (exp_req) begin
                chk("mem_addr", mem_addr_out, exp_addr);
                chk("mem_be", {28'd0, mem_byte_en_out}, {28'd0, exp_be});
                chk("mem_we", {31'd0, mem_we_out}, {31'd0, exp_we});
                if (exp_we) chk("mem_wdata", mem_wdata_out, exp_wdata);
            end
            if (mem_req_out) begin
                if (first_req_t < 0) first_req_t = tcyc;
                req_cycles++;
                cap_addr  = mem_addr_out;
                cap_wdata = mem_wdata_out;
                cap_be    = mem_byte_en_out;
                cap_we    = mem_we_out;
            end
            if (done_out) begin
                done_t  = tcyc;
                cap_mis = misalign_out;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ls_valid_in  = 1'b0;
            mem_ack_in   = 1'($urandom_range(0, 1));
            mem_rdata_in = $urandom;
            exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
            step();
        end
    endtask

    task automatic start_txn(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] d);
        first_req_t = -1; done_t = -1; req_cycles = 0; cap_mis = 1'b0;
        tcyc = 0;
        ls_valid_in = 1'b1; ls_write_in = wr; ls_size_in = sz;
        ls_unsigned_in = uns; addr_in = a; store_data_in = d;
        mem_ack_in   = 1'($urandom_range(0, 1));
        mem_rdata_in = $urandom;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
        exp_bus_err = 1'b0;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = model_be(sz, a[1:0]);
        exp_wdata = model_wd(sz, d);
        exp_we    = wr;
    endtask

    // one complete access: accept, dly request cycles ending in ack, done cycle
    task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int dly);
        logic mis;
        mis = model_mis(sz, a);
        start_txn(wr, sz, uns, a, d);
        step();
        if (!mis) begin
            for (int n = 1; n <= dly; n++) begin
                tcyc = n;
                exp_req = 1'b1; exp_stall = 1'b1;
                mem_ack_in   = (n == dly);
                mem_rdata_in = (n == dly) ? rd : $urandom;
                step();
            end
            if (!wr) exp_load = model_load(sz, uns, a[1:0], rd);
        end else begin
            exp_mis = 1'b1;
        end
        tcyc = mis ? 1 : dly + 1;
        exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1;
        mem_ack_in   = 1'($urandom_range(0, 1));
        mem_rdata_in = $urandom;
        step();
        ls_valid_in = 1'b0; mem_ack_in = 1'b0;
        exp_done = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0; exp_bus_err = 1'b0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b1;
        ls_valid_in = 1'b0; ls_write_in = 1'b0; ls_size_in = 2'b00;
        ls_unsigned_in = 1'b0; addr_in = '0; store_data_in = '0;
        mem_rdata_in = '0; mem_ack_in = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
        exp_we = 1'b0; exp_bus_err = 1'b0; exp_load = '0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0; tcyc = 0;
        first_req_t = -1; done_t = -1; req_cycles = 0;
        step();
        chk_en = 1'b1;
        chk("reset_mem_addr", mem_addr_out, 32'h0);
        chk("reset_mem_be", {28'd0, mem_byte_en_out}, 32'h0);
        chk("reset_mem_wdata", mem_wdata_out, 32'h0);
        chk("reset_mem_we", {31'd0, mem_we_out}, 32'h0);
        step();
        reset = 1'b0;
        idle(2);

        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1);
        chk("sw_addr", cap_addr, 32'h10);
        chk("sw_be", {28'd0, cap_be}, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_we", {31'd0, cap_we}, 32'h1);
        chk("sw_req_cycle", first_req_t, 1);
        chk("sw_done_cycle", done_t, 2);

        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h112233F4, 1);
        chk("lb_be", {28'd0, cap_be}, 32'h1);
        chk("lb_load", load_data_out, 32'hFFFFFFF4);
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h112233F4, 1);
        chk("lbu_load", load_data_out, 32'h000000F4);

        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hAAAA8001, 5);
        chk("lh_be", {28'd0, cap_be}, 32'h3);
        chk("lh_load", load_data_out, 32'hFFFF8001);
        chk("lh_done_cycle", done_t, 6);
        chk("lh_req_cycles", req_cycles, 5);

        idle(1);
        access(1'b1, 2'b00, 1'b0, 32'h05, 32'h000000A5, 32'h0, 2);
        chk("sb_addr", cap_addr, 32'h04);
        chk("sb_be", {28'd0, cap_be}, 32'h4);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);

        access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h12345678, 1);
        chk("lw_mis_req_cycles", req_cycles, 0);
        chk("lw_mis_flag", {31'd0, cap_mis}, 32'h1);
        chk("lw_mis_done_cycle", done_t, 1);
        chk("lw_mis_load_kept", load_data_out, 32'hFFFF8001);

        // illegal size behaves as word
        access(1'b0, 2'b11, 1'b1, 32'h40, 32'h0, 32'hCAFEF00D, 1);
        chk("size11_load", load_data_out, 32'hCAFEF00D);

        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 9) < 6) begin
                if (sz == 2'b01) a[0] = 1'b0;
                else if (sz != 2'b00) a[1:0] = 2'b00;
            end
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   $urandom, $urandom, int'($urandom_range(1, 4)));
            idle(int'($urandom_range(0, 2)));
        end

        // reset while the request is outstanding abandons it
        start_txn(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        mem_ack_in = 1'b0;
        step();
        tcyc = 1; exp_req = 1'b1; mem_ack_in = 1'b0;
        step();
        tcyc = 2; reset = 1'b1;
        step();
        reset = 1'b0; ls_valid_in = 1'b0; mem_ack_in = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_load = '0;
        done_t = -1;
        step();
        idle(2);
        chk("reset_abandon_no_done", done_t, -1);

`ifdef LSU_TIMEOUT_EN
        start_txn(1'b0, 2'b10, 1'b0, 32'hC0, 32'h0);
        mem_ack_in = 1'b0;
        step();
        for (int n = 1; n <= 16; n++) begin
            tcyc = n; exp_req = 1'b1; mem_ack_in = 1'b0;
            step();
        end
        tcyc = 17; exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_bus_err = 1'b1;
        step();
        ls_valid_in = 1'b0;
        exp_done = 1'b0; exp_bus_err = 1'b0;
        chk("timeout_done_cycle", done_t, 17);
        chk("timeout_load_kept", load_data_out, 32'h0);
        idle(2);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
